// File: rtl/source_operand_pipe_pkg.sv
// -----------------------------------------------------------------------------
// operand_pkg
// Purpose : shared definitions for the source-operand pipe.
//           - 4-bit operand-select code values
//           - reserved-code test used by the extender
// Ports   : none (package)
// -----------------------------------------------------------------------------
package operand_pkg;

  localparam logic [3:0] IS_PASS_R  = 4'b0000;  // register value as-is
  localparam logic [3:0] IS_SIMM13  = 4'b0001;  // sign-extended imm[12:0]
  localparam logic [3:0] IS_SHCNT_I = 4'b0010;  // shift count from imm[4:0]
  localparam logic [3:0] IS_SHCNT_R = 4'b0011;  // shift count from r[4:0]
  localparam logic [3:0] IS_SETHI   = 4'b0100;  // imm left-justified
  localparam logic [3:0] IS_DISP    = 4'b0101;  // word displacement
  localparam logic [3:0] IS_ZIMM    = 4'b0110;  // zero-extended imm
  localparam logic [3:0] IS_SEL_I   = 4'b0111;  // imm[13] picks S13 or r

  // The whole upper half of the code space is reserved.
  function automatic logic is_reserved(input logic [3:0] sel);
    return sel[3];
  endfunction

endpackage

// File: rtl/source_operand_pipe_if.sv
// -----------------------------------------------------------------------------
// source_operand_pipe_if
// Purpose : bundles the request handshake, result handshake and status of the
//           source-operand pipe.
// Signals : in_valid/in_ready/in_is/in_r/in_imm   request side
//           out_valid/out_ready/out_n/out_illegal result side (FIFO head)
//           occupancy/err_count                   status
// Modports: master - the surrounding pipeline (drives requests, consumes results)
//           slave  - the operand pipe itself
// -----------------------------------------------------------------------------
interface source_operand_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 22,
  parameter int DEPTH  = 2
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_is;
  logic [DATA_W-1:0] in_r;
  logic [IMM_W-1:0]  in_imm;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_n;
  logic              out_illegal;

  logic [CNT_W-1:0]  occupancy;
  logic [7:0]        err_count;

  modport master (
    output in_valid, in_is, in_r, in_imm, out_ready,
    input  in_ready, out_valid, out_n, out_illegal, occupancy, err_count
  );

  modport slave (
    input  in_valid, in_is, in_r, in_imm, out_ready,
    output in_ready, out_valid, out_n, out_illegal, occupancy, err_count
  );

endinterface

// File: rtl/source_operand_ext.sv
// -----------------------------------------------------------------------------
// source_operand_ext
// Purpose : combinational operand former. Maps an operand-select code plus
//           register value and immediate field to the second ALU operand.
//           Reserved codes give a zero result with the illegal flag set.
// Ports   : i_is      select code
//           i_r       register-file value
//           i_imm     immediate field
//           o_illegal select code was reserved
//           o_result  formed operand
// -----------------------------------------------------------------------------
module source_operand_ext
  import operand_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 22
) (
  input  logic [3:0]        i_is,
  input  logic [DATA_W-1:0] i_r,
  input  logic [IMM_W-1:0]  i_imm,
  output logic              o_illegal,
  output logic [DATA_W-1:0] o_result
);

  logic [DATA_W-1:0]       w_s13;
  logic signed [IMM_W+1:0] w_disp_raw;
  logic [DATA_W-1:0]       w_disp;

  assign w_s13 = {{(DATA_W-13){i_imm[12]}}, i_imm[12:0]};

  // Cast of a signed value to a wider size sign-extends; this also copes with
  // DATA_W == IMM_W+2 where an explicit replication count would be zero.
  assign w_disp_raw = {i_imm, 2'b00};
  assign w_disp     = DATA_W'(w_disp_raw);

  always_comb begin
    o_illegal = 1'b0;
    o_result  = '0;
    if (is_reserved(i_is)) begin
      o_illegal = 1'b1;
    end else begin
      case (i_is)
        IS_PASS_R:  o_result = i_r;
        IS_SIMM13:  o_result = w_s13;
        IS_SHCNT_I: o_result = DATA_W'(i_imm[4:0]);
        IS_SHCNT_R: o_result = DATA_W'(i_r[4:0]);
        IS_SETHI:   o_result = {i_imm, {(DATA_W-IMM_W){1'b0}}};
        IS_DISP:    o_result = w_disp;
        IS_ZIMM:    o_result = DATA_W'(i_imm);
        IS_SEL_I:   o_result = i_imm[13] ? w_s13 : i_r;
        default:    o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/source_operand_pipe.sv
// -----------------------------------------------------------------------------
// source_operand_pipe
// Purpose : forms the second ALU operand from the decoded request and queues
//           {illegal, result} in a small FIFO so the execute stage can stall
//           without losing operands. Counts accepted reserved-code requests.
// Ports   : clk    single clock, rising edge
//           reset  synchronous, active-high
//           bus    source_operand_pipe_if.slave (request, result, status)
// -----------------------------------------------------------------------------
module source_operand_pipe
  import operand_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 22,
  parameter int DEPTH  = 2
) (
  input logic                  clk,
  input logic                  reset,
  source_operand_pipe_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  if (DATA_W < IMM_W + 2) begin : g_bad_width
    $error("source_operand_pipe: DATA_W must be at least IMM_W+2");
  end
  if (IMM_W < 14) begin : g_bad_imm
    $error("source_operand_pipe: IMM_W must be at least 14");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("source_operand_pipe: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic              illegal;
    logic [DATA_W-1:0] result;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [7:0]        r_err_count;

  logic              w_ext_illegal;
  logic [DATA_W-1:0] w_ext_result;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_push;
  logic              w_pop;
  entry_t            w_head;

  source_operand_ext #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_ext (
    .i_is      (bus.in_is),
    .i_r       (bus.in_r),
    .i_imm     (bus.in_imm),
    .o_illegal (w_ext_illegal),
    .o_result  (w_ext_result)
  );

  // in_ready depends only on the registered count, so a stalled consumer
  // never reaches back combinationally into decode.
  assign w_in_ready  = (r_count < CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_head      = r_mem[r_rd_ptr];

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_n       = w_out_valid ? w_head.result : '0;
  assign bus.out_illegal = w_out_valid & w_head.illegal;
  assign bus.occupancy   = r_count;
  assign bus.err_count   = r_err_count;

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= '{illegal: w_ext_illegal, result: w_ext_result};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_err_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_ext_illegal && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_source_operand_pipe.sv
module tb_source_operand_pipe;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 22;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic        ill;
    logic [31:0] res;
  } exp_t;

  logic clk;
  logic reset;

  source_operand_pipe_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .DEPTH(DEPTH)) bus ();

  source_operand_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  int   checks = 0;
  int   errors = 0;
  exp_t mq[$];
  int   m_err = 0;
  bit   last_push;

  // Reference operand former, written as plain arithmetic on the field values.
  function automatic exp_t ref_op(input logic [3:0] sel, input logic [31:0] r,
                                  input logic [21:0] imm);
    exp_t   e;
    longint s13;
    longint v;
    s13 = longint'(imm) % 8192;
    if (s13 >= 4096) s13 = s13 - 8192;
    e.ill = 1'b0;
    v = 0;
    if (sel >= 4'd8) begin
      e.ill = 1'b1;
      v = 0;
    end else begin
      case (sel)
        4'd0: v = longint'(r);
        4'd1: v = s13;
        4'd2: v = longint'(imm) % 32;
        4'd3: v = longint'(r) % 32;
        4'd4: v = longint'(imm) * 1024;
        4'd5: begin
          v = longint'(imm) * 4;
          if (v >= 64'sd8388608) v = v - 64'sd16777216;
        end
        4'd6: v = longint'(imm);
        default: v = (((longint'(imm) / 8192) % 2) == 1) ? s13 : longint'(r);
      endcase
    end
    e.res = v[31:0];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    exp_t head;
    head = (mq.size() > 0) ? mq[0] : '0;
    chk("in_ready",    64'(bus.in_ready),    64'(mq.size() < DEPTH));
    chk("occupancy",   64'(bus.occupancy),   64'(mq.size()));
    chk("out_valid",   64'(bus.out_valid),   64'(mq.size() > 0));
    chk("out_n",       64'(bus.out_n),       64'(head.res));
    chk("out_illegal", 64'(bus.out_illegal), 64'(head.ill));
    chk("err_count",   64'(bus.err_count),   64'(m_err));
  endtask

  // One clock: update the model from the values present at the edge, then
  // compare on the falling edge.
  task automatic tick();
    bit   push;
    bit   pop;
    exp_t e;
    @(posedge clk);
    push = bus.in_valid && (mq.size() < DEPTH);
    pop  = bus.out_ready && (mq.size() > 0);
    e    = ref_op(bus.in_is, bus.in_r, bus.in_imm);
    if (reset) begin
      mq.delete();
      m_err = 0;
      last_push = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(e);
        if (e.ill && m_err < 255) m_err++;
      end
      last_push = push;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [3:0] sel, input logic [31:0] r,
                       input logic [21:0] imm, input bit ordy);
    bus.in_valid  = v;
    bus.in_is     = sel;
    bus.in_r      = r;
    bus.in_imm    = imm;
    bus.out_ready = ordy;
  endtask

  logic [31:0] sweep_exp [8];
  logic [31:0] bp_exp [3];
  logic [31:0] drained [3];
  int          got;
  bit          acc;

  initial begin
    sweep_exp = '{32'hE0000003, 32'hFFFFF113, 32'h00000013, 32'h00000003,
                  32'h8C444C00, 32'hFF8C444C, 32'h00231113, 32'hE0000003};
    bp_exp    = '{32'hE0000003, 32'h00231113, 32'h8C444C00};

    // Reset state
    reset = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 22'h0, 1'b1);
    @(negedge clk);
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b0;

    // Code sweep, one per cycle
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'(k), 32'hE0000003, 22'h231113, 1'b1);
      tick();
      chk("sweep_n", 64'(bus.out_n), 64'(sweep_exp[k]));
    end

    // imm[13] steering and positive S13
    drive(1'b1, 4'd7, 32'hE0000003, 22'h233113, 1'b1);
    tick();
    chk("sel_i_bit13", 64'(bus.out_n), 64'hFFFFF113);
    drive(1'b1, 4'd1, 32'hE0000003, 22'h230113, 1'b1);
    tick();
    chk("simm13_pos", 64'(bus.out_n), 64'h00000113);
    drive(1'b0, 4'd0, 32'h0, 22'h0, 1'b1);
    tick();

    // Backpressure: third request held while full
    drive(1'b1, 4'd0, 32'hE0000003, 22'h231113, 1'b0);
    tick();
    drive(1'b1, 4'd6, 32'hE0000003, 22'h231113, 1'b0);
    tick();
    drive(1'b1, 4'd4, 32'hE0000003, 22'h231113, 1'b0);
    tick();
    chk("bp_occ", 64'(bus.occupancy), 64'd2);
    chk("bp_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.out_ready = 1'b1;
    got = 0;
    acc = 1'b0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      if (bus.out_valid) begin
        drained[got] = bus.out_n;
        got++;
      end
      tick();
      if (last_push) begin
        acc = 1'b1;
        bus.in_valid = 1'b0;
      end
    end
    chk("bp_accepted", 64'(acc), 64'd1);
    chk("bp_drained", 64'(got), 64'd3);
    for (int i = 0; i < 3; i++) chk("bp_order", 64'(drained[i]), 64'(bp_exp[i]));
    drive(1'b0, 4'd0, 32'h0, 22'h0, 1'b1);
    tick();

    // Reserved codes
    for (int k = 8; k < 16; k++) begin
      drive(1'b1, 4'(k), $urandom(), 22'($urandom()), 1'b1);
      tick();
      chk("rsv_illegal", 64'(bus.out_illegal), 64'd1);
      chk("rsv_zero", 64'(bus.out_n), 64'd0);
    end
    chk("err_eight", 64'(bus.err_count), 64'd8);
    for (int k = 0; k < 252; k++) begin
      drive(1'b1, {1'b1, 3'($urandom())}, $urandom(), 22'($urandom()), 1'b1);
      tick();
    end
    chk("err_sat", 64'(bus.err_count), 64'd255);
    drive(1'b0, 4'd0, 32'h0, 22'h0, 1'b1);
    tick();

    // Simultaneous push and pop at occupancy 1
    drive(1'b1, 4'd0, $urandom(), 22'($urandom()), 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 4'($urandom_range(0, 7)), $urandom(), 22'($urandom()), 1'b1);
      tick();
      chk("pp_occ", 64'(bus.occupancy), 64'd1);
    end
    drive(1'b0, 4'd0, 32'h0, 22'h0, 1'b1);
    tick();

    // Reset with occupancy 2 and err_count 5
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'd9, $urandom(), 22'($urandom()), 1'b1);
      tick();
    end
    drive(1'b1, 4'd0, 32'hA5A5_0001, 22'h0, 1'b0);
    tick();
    tick();
    chk("pre_rst_occ", 64'(bus.occupancy), 64'd2);
    chk("pre_rst_err", 64'(bus.err_count), 64'd5);
    reset = 1'b1;
    drive(1'b1, 4'd0, 32'h1, 22'h1, 1'b1);
    tick();
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_occ", 64'(bus.occupancy), 64'd0);
    chk("mrst_err", 64'(bus.err_count), 64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b0;
    drive(1'b1, 4'd3, 32'h1234_5677, 22'h0, 1'b1);
    tick();
    chk("post_rst_n", 64'(bus.out_n), 64'h17);
    drive(1'b0, 4'd0, 32'h0, 22'h0, 1'b1);
    tick();

    // Random traffic with occasional mid-stream reset
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 63) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!(bus.in_valid && mq.size() >= DEPTH)) begin
        bus.in_valid = $urandom_range(0, 1);
        bus.in_is    = 4'($urandom_range(0, 15));
        bus.in_r     = $urandom();
        bus.in_imm   = 22'($urandom());
      end
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
